// File: rtl/encoder_sequencer_if.sv
// encoder_sequencer_if
//   Handshake bundle between the encoder round/stage sequencer and the
//   slice stages it drives.
//
//   Parameter:
//     NUM_STAGES  width of the per-stage start/done vectors
//
//   Signals:
//     start        run request (into the sequencer)
//     stage_done   per-stage Done, bit i from stage i (into the sequencer)
//     ready        sequencer idle
//     done         one-cycle run-complete pulse
//     stage_start  one-hot start pulse to the current stage
//     stage_index  current stage number
//     round_index  current round number
//     buf_sel      ping-pong page the current stage reads
//     err          sticky watchdog error
//
//   Modports:
//     master  the sequencer
//     slave   the stage side / run requester
interface encoder_sequencer_if #(
  parameter int NUM_STAGES = 5
);
  logic                  start;
  logic [NUM_STAGES-1:0] stage_done;
  logic                  ready;
  logic                  done;
  logic [NUM_STAGES-1:0] stage_start;
  logic [2:0]            stage_index;
  logic [4:0]            round_index;
  logic                  buf_sel;
  logic                  err;

  modport master (
    input  start, stage_done,
    output ready, done, stage_start, stage_index, round_index, buf_sel, err
  );

  modport slave (
    output start, stage_done,
    input  ready, done, stage_start, stage_index, round_index, buf_sel, err
  );
endinterface

// File: rtl/encoder_sequencer.sv
// encoder_sequencer
//   Round/stage controller for the encoder. Launches the per-round slice
//   stages in order for NUM_ROUNDS rounds using each stage's start/Done
//   handshake, flips the ping-pong page buffer after every completed stage
//   and reports the current round and stage indices.
//
//   Parameters:
//     NUM_STAGES  stages per round (1..8)
//     NUM_ROUNDS  rounds per run (1..32)
//     TIMEOUT     watchdog limit in WAIT cycles (2..65535)
//
//   Ports:
//     clk    sole clock, rising edge
//     reset  synchronous, active-high; returns the block to IDLE
//     bus    encoder_sequencer_if.master (start, stage_done in;
//            ready, done, stage_start, stage_index, round_index,
//            buf_sel, err out)
//
//   Optional feature:
//     SEQ_TIMEOUT_EN  when defined, adds a 16-bit WAIT watchdog and a
//                     sticky ERR state left only by reset. When undefined,
//                     WAIT waits indefinitely and err is tied 0.
//
//   Every output is decoded from registered state; there is no
//   combinational path from start/stage_done to any output.
module encoder_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_ROUNDS = 24,
  parameter int TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                reset,
  encoder_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd3;
`ifdef SEQ_TIMEOUT_EN
  localparam logic [2:0] ST_ERR    = 3'd4;
  // Last watchdog value that still allows another WAIT cycle; the miss
  // taken at this value is the TIMEOUT-th one.
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
`endif

  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  generate
    if (NUM_STAGES < 1 || NUM_STAGES > 8 || NUM_ROUNDS < 1 || NUM_ROUNDS > 32 ||
        TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_params
      $error("encoder_sequencer: parameter out of legal range");
    end
  endgenerate

  logic [2:0] state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [4:0] round_q, round_d;
  logic       buf_q,   buf_d;
`ifdef SEQ_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
`endif

  // One-hot decode of the current stage; used both to select the Done bit
  // being waited on and to steer the start pulse.
  logic [NUM_STAGES-1:0] stage_hit;
  logic                  cur_done;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign stage_hit[gi]       = (stage_q == 3'(gi));
      assign bus.stage_start[gi] = (state_q == ST_LAUNCH) && stage_hit[gi];
    end
  endgenerate

  // Only the Done of the stage being waited on counts; all others are stray.
  assign cur_done = |(bus.stage_done & stage_hit);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    round_d = round_q;
    buf_d   = buf_q;
`ifdef SEQ_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          stage_d = 3'd0;
          round_d = 5'd0;
          buf_d   = 1'b0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Done in the launch cycle is deliberately not looked at.
        state_d = ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
        wd_d    = 16'd0;
`endif
      end
      ST_WAIT: begin
        if (cur_done) begin
          // The finished stage wrote the other page; it becomes the source.
          buf_d = ~buf_q;
          if (stage_q < LAST_STAGE) begin
            stage_d = stage_q + 3'd1;
            state_d = ST_LAUNCH;
          end else if (round_q < LAST_ROUND) begin
            stage_d = 3'd0;
            round_d = round_q + 5'd1;
            state_d = ST_LAUNCH;
          end else begin
            stage_d = 3'd0;
            round_d = 5'd0;
            state_d = ST_FINISH;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        // A Done arriving on the final allowed cycle wins over the timeout.
        else if (wd_q == WD_LAST) begin
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      ST_FINISH: begin
        // buf_sel is held so it names the page holding the final result.
        state_d = ST_IDLE;
      end
`ifdef SEQ_TIMEOUT_EN
      ST_ERR: begin
        state_d = ST_ERR;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= 3'd0;
      round_q <= 5'd0;
      buf_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      round_q <= round_d;
      buf_q   <= buf_d;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus.ready       = (state_q == ST_IDLE);
  assign bus.done        = (state_q == ST_FINISH);
  assign bus.stage_index = stage_q;
  assign bus.round_index = round_q;
  assign bus.buf_sel     = buf_q;
`ifdef SEQ_TIMEOUT_EN
  assign bus.err         = (state_q == ST_ERR);
`else
  assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_sequencer.sv
// tb_encoder_sequencer
//   Self-checking bench for encoder_sequencer (NUM_STAGES=5, NUM_ROUNDS=24,
//   TIMEOUT=16). Stage latencies are held in a per-(round,stage) table; the
//   expected timeline of every run is derived from those latencies with
//   plain arithmetic and compared against the DUT every cycle.
module tb_encoder_sequencer;
  localparam int NS  = 5;
  localparam int NR  = 24;
  localparam int TMO = 16;
  localparam int NJ  = NS * NR;

  logic clk = 1'b0;
  logic reset;

  encoder_sequencer_if #(.NUM_STAGES(NS)) bus ();

  encoder_sequencer #(
    .NUM_STAGES(NS),
    .NUM_ROUNDS(NR),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int lat[NJ];

  typedef struct {
    int base_k;
    int slow_stage;
    int slow_k;
    bit noise;
    bit hold;
    int exp_done;
    int exp_r1;
  } vec_t;

  vec_t tab[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ready"},       32'(bus.ready),       32'd1);
    check({tag, " done"},        32'(bus.done),        32'd0);
    check({tag, " stage_start"}, 32'(bus.stage_start), 32'd0);
    check({tag, " stage_index"}, 32'(bus.stage_index), 32'd0);
    check({tag, " round_index"}, 32'(bus.round_index), 32'd0);
    check({tag, " buf_sel"},     32'(bus.buf_sel),     32'd0);
    check({tag, " err"},         32'(bus.err),         32'd0);
  endtask

  // Runs one sequence from an IDLE negedge. Cycle t is checked and driven at
  // its negedge. Returns at the negedge of the first IDLE cycle after done
  // (or, when aborted by reset, at an IDLE negedge with reset released).
  task automatic do_run(input bit noise, input bit hold_start, input int abort_j,
                        output int done_at, output int r1_at);
    int L[NJ];
    int t_end;
    int j;
    int s;
    logic [NS-1:0] onehot;
    logic [NS-1:0] rnd;
    L[0] = 1;
    for (int i = 1; i < NJ; i++) L[i] = L[i-1] + 1 + lat[i-1];
    t_end   = L[NJ-1] + 1 + lat[NJ-1];
    done_at = -1;
    r1_at   = -1;
    for (int t = 0; t <= t_end; t++) begin
      if (t > 0) @(negedge clk);
      if (bus.done === 1'b1 && done_at < 0) done_at = t;
      if (bus.round_index == 5'd1 && bus.stage_start[0] === 1'b1 && r1_at < 0) r1_at = t;
      rnd = NS'($urandom);
      check($sformatf("c%0d err", t), 32'(bus.err), 32'd0);
      if (t == 0) begin
        check($sformatf("c%0d ready", t), 32'(bus.ready), 32'd1);
        check($sformatf("c%0d done", t),  32'(bus.done),  32'd0);
        check($sformatf("c%0d stage_start", t), 32'(bus.stage_start), 32'd0);
        bus.start      = 1'b1;
        bus.stage_done = noise ? rnd : '0;
      end else if (t < t_end) begin
        j = 0;
        for (int i = 0; i < NJ; i++) if (t >= L[i] && t <= L[i] + lat[i]) j = i;
        s      = j % NS;
        onehot = NS'(1) << s;
        check($sformatf("c%0d ready", t), 32'(bus.ready), 32'd0);
        check($sformatf("c%0d done", t),  32'(bus.done),  32'd0);
        check($sformatf("c%0d stage_start", t), 32'(bus.stage_start),
              (t == L[j]) ? 32'(onehot) : 32'd0);
        check($sformatf("c%0d stage_index", t), 32'(bus.stage_index), 32'(s));
        check($sformatf("c%0d round_index", t), 32'(bus.round_index), 32'(j / NS));
        check($sformatf("c%0d buf_sel", t),     32'(bus.buf_sel),     32'(j % 2));
        if (j == abort_j && t == L[j] + 1) begin
          reset          = 1'b1;
          bus.start      = 1'b1;
          bus.stage_done = '1;
          @(negedge clk);
          check_reset_vals($sformatf("reset r%0d s%0d", j / NS, s));
          reset          = 1'b0;
          bus.start      = 1'b0;
          bus.stage_done = '0;
          return;
        end
        bus.start = noise ? 1'($urandom) : 1'b0;
        if (t == L[j] + lat[j])
          bus.stage_done = onehot | (noise ? rnd : '0);
        else if (t == L[j])
          bus.stage_done = noise ? rnd : '0;          // includes own bit: must be lost
        else
          bus.stage_done = noise ? (rnd & ~onehot) : '0;
      end else begin
        check($sformatf("c%0d done", t),  32'(bus.done),  32'd1);
        check($sformatf("c%0d ready", t), 32'(bus.ready), 32'd0);
        check($sformatf("c%0d stage_start", t), 32'(bus.stage_start), 32'd0);
        check($sformatf("c%0d stage_index", t), 32'(bus.stage_index), 32'd0);
        check($sformatf("c%0d round_index", t), 32'(bus.round_index), 32'd0);
        check($sformatf("c%0d buf_sel", t),     32'(bus.buf_sel),     32'(NJ % 2));
        bus.start      = hold_start;
        bus.stage_done = noise ? rnd : '0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int done_at;
    int r1_at;
    vec_t v;
    bit hold;

    tab[0] = '{1, 0, 1, 1'b0, 1'b0, 241, 11};
    tab[1] = '{1, 2, 3, 1'b0, 1'b0, 289, 13};
    tab[2] = '{2, 0, 2, 1'b1, 1'b0, 361, 16};
    tab[3] = '{1, 4, 5, 1'b1, 1'b1, 337, 15};
    tab[4] = '{4, 0, 1, 1'b1, 1'b0, 529, 23};

    reset          = 1'b1;
    bus.start      = 1'b1;
    bus.stage_done = '1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset init");
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.stage_done = '0;
    @(negedge clk);

    // Table-driven runs: fixed latency profiles with hand-computed timing.
    for (int n = 0; n < 5; n++) begin
      v = tab[n];
      for (int i = 0; i < NJ; i++) lat[i] = (i % NS == v.slow_stage) ? v.slow_k : v.base_k;
      do_run(v.noise, v.hold, -1, done_at, r1_at);
      check($sformatf("vec%0d done_cycle", n), 32'(done_at), 32'(v.exp_done));
      check($sformatf("vec%0d round1_launch", n), 32'(r1_at), 32'(v.exp_r1));
      $display("vec %0d: done at cycle %0d, round 1 launch at cycle %0d", n, done_at, r1_at);
    end

    // Randomized runs: random latencies, stray Done bits, stray start.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NJ; i++) lat[i] = $urandom_range(1, 4);
      hold = 1'($urandom);
      do_run(1'b1, hold, -1, done_at, r1_at);
      $display("random run %0d: done at cycle %0d (hold_start=%0d)", n, done_at, hold);
    end

    // Reset in round 10, stage 3.
    for (int i = 0; i < NJ; i++) lat[i] = 1;
    do_run(1'b0, 1'b0, 10 * NS + 3, done_at, r1_at);
    $display("reset abort run: reset applied in round 10 stage 3");

    // Stage 0 never answers.
    bus.start      = 1'b1;
    bus.stage_done = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check("hang launch stage_start", 32'(bus.stage_start), 32'd1);
`ifdef SEQ_TIMEOUT_EN
    for (int w = 1; w <= TMO; w++) begin
      bus.stage_done = NS'($urandom) & ~NS'(1);
      @(negedge clk);
      check($sformatf("wait%0d err", w),   32'(bus.err),   32'd0);
      check($sformatf("wait%0d ready", w), 32'(bus.ready), 32'd0);
    end
    bus.stage_done = '0;
    @(negedge clk);
    check("timeout err", 32'(bus.err), 32'd1);
    bus.start      = 1'b1;
    bus.stage_done = '1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check($sformatf("err hold%0d err", w),         32'(bus.err),         32'd1);
      check($sformatf("err hold%0d ready", w),       32'(bus.ready),       32'd0);
      check($sformatf("err hold%0d stage_start", w), 32'(bus.stage_start), 32'd0);
    end
    $display("timeout: err raised after %0d silent WAIT cycles", TMO);
`else
    for (int w = 1; w <= 40; w++) begin
      bus.stage_done = NS'($urandom) & ~NS'(1);
      bus.start      = 1'($urandom);
      @(negedge clk);
      check($sformatf("wait%0d err", w),         32'(bus.err),         32'd0);
      check($sformatf("wait%0d ready", w),       32'(bus.ready),       32'd0);
      check($sformatf("wait%0d stage_start", w), 32'(bus.stage_start), 32'd0);
      check($sformatf("wait%0d stage_index", w), 32'(bus.stage_index), 32'd0);
    end
    $display("no watchdog: still waiting on stage 0 after 40 cycles");
`endif
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("reset final");
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.stage_done = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
